// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Initiator side of the ALU datapath. Accepts one operation request at a
// time, reads its operands from a small internal register file, drives the
// ALU's A/B/func inputs from registers, captures the combinational ALU
// result one cycle later and writes it back to the register file.
//
// Request handshake (valid/ready):
//   A request transfers on a rising clk edge where instr_valid and
//   instr_ready are both high. instr_ready depends only on the sequencer
//   state (never on instr_valid). While instr_ready is low the request is
//   ignored, and the source must hold instr_valid and all instr_* fields
//   stable until the transfer edge.
//
// Operation timeline (one op every three cycles):
//   IDLE  - instr_ready=1; on accept the operands/func are registered.
//   EXEC  - alu_a/alu_b/alu_func held stable for a full cycle; at the end
//           of this cycle the ALU result is written back.
//   WB    - res_valid is high for exactly this cycle.
//   A dependent op accepted in the following IDLE cycle reads the freshly
//   written value, so no forwarding path exists.
//
// Optional feature (compile-time macro ALU_SEQ_R0_ZERO_EN):
//   Defined   - register 0 reads as zero (operands and dbg port) and writes
//               with rd=0 are dropped; res_valid/res_data/res_rd still
//               report the ALU result with res_rd=0.
//   Undefined - register 0 is an ordinary register.

module alu_op_sequencer #(
    parameter int N    = 32,
    parameter int REGS = 16
) (
    input  logic         clk,
    input  logic         rst,

    // Operation request
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [3:0]   instr_func,
    input  logic [3:0]   instr_rd,
    input  logic [3:0]   instr_rs,
    input  logic [3:0]   instr_rt,
    input  logic         instr_use_imm,
    input  logic [N-1:0] instr_imm,

    // ALU interface
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_func,
    input  logic [N-1:0] alu_res,

    // Writeback report
    output logic         res_valid,
    output logic [N-1:0] res_data,
    output logic [3:0]   res_rd,

    // Register file debug read
    input  logic [3:0]   dbg_addr,
    output logic [N-1:0] dbg_data
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [N-1:0] regfile [REGS];
    logic [3:0]   rd_q;          // destination of the op in flight

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic         accept;        // request transfers on this edge
    logic         wb_en;         // ALU result is captured on this edge
    logic         rf_we;         // register file actually written
    logic [N-1:0] op_a;          // operand A as read from the regfile
    logic [N-1:0] op_b;          // operand B (register or immediate)
    logic [N-1:0] rs_val;
    logic [N-1:0] rt_val;

    // Register file read port model. With the r0-zero option, address 0
    // always reads as zero regardless of what the storage holds.
    function automatic logic [N-1:0] rf_read(input logic [3:0] addr);
`ifdef ALU_SEQ_R0_ZERO_EN
        if (addr == 4'd0) begin
            return '0;
        end
`endif
        return regfile[addr];
    endfunction

    // Operand reads happen combinationally in IDLE so they see any write
    // committed at the end of the previous EXEC cycle.
    always_comb begin
        rs_val = rf_read(instr_rs);
        rt_val = rf_read(instr_rt);
        op_a   = rs_val;
        op_b   = instr_use_imm ? instr_imm : rt_val;
    end

    // Debug read port reflects a write from the edge on which it occurs.
    always_comb begin
        dbg_data = rf_read(dbg_addr);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Advance the sequencer state; reset returns to IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state and handshake decode
    // ------------------------------------------------------------------
    // Decode ready/accept and the next state from the current state.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        wb_en       = 1'b0;
        case (state)
            IDLE: begin
                // Reset holds the state at IDLE; keep ready low while
                // reset is still asserted.
                instr_ready = ~rst;
                accept      = instr_valid & ~rst;
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                wb_en      = 1'b1;
                state_next = WB;
            end
            WB: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Suppress the storage write for r0 when it is hardwired to zero.
    always_comb begin
`ifdef ALU_SEQ_R0_ZERO_EN
        rf_we = wb_en & (rd_q != 4'd0);
`else
        rf_we = wb_en;
`endif
    end

    // ------------------------------------------------------------------
    // ALU operand registers
    // ------------------------------------------------------------------
    // Load A/B/func and the destination on accept; hold them otherwise so
    // the ALU sees stable inputs through EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_func <= 4'd0;
            rd_q     <= 4'd0;
        end else if (accept) begin
            alu_a    <= op_a;
            alu_b    <= op_b;
            alu_func <= instr_func;
            rd_q     <= instr_rd;
        end
    end

    // ------------------------------------------------------------------
    // Writeback report
    // ------------------------------------------------------------------
    // Capture the ALU result at the end of EXEC and pulse res_valid for the
    // WB cycle; res_data/res_rd hold until the next writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= 4'd0;
        end else begin
            res_valid <= wb_en;
            if (wb_en) begin
                res_data <= alu_res;
                res_rd   <= rd_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file storage
    // ------------------------------------------------------------------
    // Clear every entry on reset; otherwise commit the ALU result to rd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                regfile[i] <= '0;
            end
        end else if (rf_we) begin
            regfile[rd_q] <= alu_res;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//
// Drives alu_op_sequencer with a small ALU model on its alu_* outputs.
// Directed vectors come from a table of constants; a random phase is
// checked against a register-array reference model.
// Build option ALU_SEQ_R0_ZERO_EN selects the r0-hardwired expectations.

module tb_alu_op_sequencer;

    localparam int N = 32;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst;

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic         instr_valid;
    logic         instr_ready;
    logic [3:0]   instr_func;
    logic [3:0]   instr_rd;
    logic [3:0]   instr_rs;
    logic [3:0]   instr_rt;
    logic         instr_use_imm;
    logic [N-1:0] instr_imm;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_func;
    logic [N-1:0] alu_res;
    logic         res_valid;
    logic [N-1:0] res_data;
    logic [3:0]   res_rd;
    logic [3:0]   dbg_addr;
    logic [N-1:0] dbg_data;

    alu_op_sequencer #(.N(N), .REGS(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_func    (instr_func),
        .instr_rd      (instr_rd),
        .instr_rs      (instr_rs),
        .instr_rt      (instr_rt),
        .instr_use_imm (instr_use_imm),
        .instr_imm     (instr_imm),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_func      (alu_func),
        .alu_res       (alu_res),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_rd        (res_rd),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    // ------------------------------------------------------------------
    // ALU behaviour (environment) and reference model
    // ------------------------------------------------------------------
    function automatic logic [N-1:0] alu_fn(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [3:0]   f);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            default: return a;
        endcase
    endfunction

    always_comb alu_res = alu_fn(alu_a, alu_b, alu_func);

    logic [N-1:0] model_rf [16];

    function automatic logic [N-1:0] model_read(input logic [3:0] addr);
`ifdef ALU_SEQ_R0_ZERO_EN
        if (addr == 4'd0) return '0;
`endif
        return model_rf[addr];
    endfunction

    task automatic model_write(input logic [3:0] rd, input logic [N-1:0] v);
`ifdef ALU_SEQ_R0_ZERO_EN
        if (rd != 4'd0) model_rf[rd] = v;
`else
        model_rf[rd] = v;
`endif
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_rf[i] = '0;
    endtask

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reg(input logic [3:0] addr);
        dbg_addr = addr;
        #1;
        check($sformatf("dbg_r%0d", addr), dbg_data, model_read(addr));
    endtask

    // ------------------------------------------------------------------
    // Driver: one complete op. Called and returning at a negedge in IDLE.
    // ------------------------------------------------------------------
    task automatic do_op(input logic [3:0] f, input logic [3:0] rd,
                         input logic [3:0] rs, input logic [3:0] rt,
                         input logic ui, input logic [N-1:0] imm,
                         input logic use_tbl, input logic [N-1:0] tbl_exp);
        logic [N-1:0] ea;
        logic [N-1:0] eb;
        logic [N-1:0] eres;
        ea   = model_read(rs);
        eb   = ui ? imm : model_read(rt);
        eres = use_tbl ? tbl_exp : alu_fn(ea, eb, f);

        instr_func = f; instr_rd = rd; instr_rs = rs; instr_rt = rt;
        instr_use_imm = ui; instr_imm = imm; instr_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (instr_ready) break;
            @(negedge clk);
        end
        if (!instr_ready) begin
            check("accept_timeout", {31'd0, instr_ready}, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;

        @(negedge clk);   // EXEC
        check("exec_alu_a", alu_a, ea);
        check("exec_alu_b", alu_b, eb);
        check("exec_alu_func", {28'd0, alu_func}, {28'd0, f});
        check("exec_ready", {31'd0, instr_ready}, 32'd0);
        check("exec_res_valid", {31'd0, res_valid}, 32'd0);

        @(negedge clk);   // WB
        model_write(rd, eres);
        check("wb_res_valid", {31'd0, res_valid}, 32'd1);
        check("wb_res_data", res_data, eres);
        check("wb_res_rd", {28'd0, res_rd}, {28'd0, rd});
        check("wb_alu_a_held", alu_a, ea);
        check_reg(rd);

        @(negedge clk);   // back in IDLE
        check("idle_res_valid", {31'd0, res_valid}, 32'd0);
        check("idle_ready", {31'd0, instr_ready}, 32'd1);
        check("idle_res_data_held", res_data, eres);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]   func;
        logic [3:0]   rd;
        logic [3:0]   rs;
        logic [3:0]   rt;
        logic         use_imm;
        logic [N-1:0] imm;
        logic [N-1:0] exp_res;
    } vec_t;

    vec_t vecs [8];

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rdy_exp [4];
        logic [3:0] f, rd, rs, rt;
        logic       ui;
        logic [N-1:0] imm;

        vecs[0] = '{4'd0, 4'd1,  4'd0, 4'd0, 1'b1, 32'd5,      32'h0000_0005};
        vecs[1] = '{4'd1, 4'd2,  4'd1, 4'd0, 1'b1, 32'd7,      32'hFFFF_FFFE};
        vecs[2] = '{4'd0, 4'd3,  4'd0, 4'd0, 1'b1, 32'hF0F0,   32'h0000_F0F0};
        vecs[3] = '{4'd0, 4'd4,  4'd0, 4'd0, 1'b1, 32'h0FF0,   32'h0000_0FF0};
        vecs[4] = '{4'd2, 4'd9,  4'd3, 4'd4, 1'b0, 32'hDEAD,   32'h0000_00F0};
        vecs[5] = '{4'd3, 4'd10, 4'd3, 4'd4, 1'b0, 32'hBEEF,   32'h0000_FFF0};
        vecs[6] = '{4'd0, 4'd11, 4'd2, 4'd2, 1'b0, 32'd0,      32'hFFFF_FFFC};
        vecs[7] = '{4'd1, 4'd2,  4'd2, 4'd1, 1'b0, 32'd1,      32'hFFFF_FFF9};

        // Reset
        rst = 1'b1;
        instr_valid = 1'b0; instr_func = '0; instr_rd = '0; instr_rs = '0;
        instr_rt = '0; instr_use_imm = 1'b0; instr_imm = '0; dbg_addr = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_ready_low", {31'd0, instr_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_alu_a", alu_a, '0);
        check("rst_alu_b", alu_b, '0);
        check("rst_alu_func", {28'd0, alu_func}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", res_data, '0);
        check("rst_res_rd", {28'd0, res_rd}, 32'd0);
        for (int i = 0; i < 16; i++) check_reg(i[3:0]);
        @(negedge clk);

        // Table-driven directed ops
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].func, vecs[i].rd, vecs[i].rs, vecs[i].rt,
                  vecs[i].use_imm, vecs[i].imm, 1'b1, vecs[i].exp_res);
        end

        // Back-to-back xor with valid held high: ready pattern 1,0,0,1
        rdy_exp[0] = 4'd1; rdy_exp[1] = 4'd0; rdy_exp[2] = 4'd0; rdy_exp[3] = 4'd1;
        instr_func = 4'd4; instr_rd = 4'd5; instr_rs = 4'd3; instr_rt = 4'd4;
        instr_use_imm = 1'b0; instr_imm = 32'h1234; instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_ready_%0d", i), {31'd0, instr_ready},
                  {28'd0, rdy_exp[i]});
            if (i == 2) begin
                check("b2b_res_data", res_data, 32'h0000_FF00);
                check("b2b_res_rd", {28'd0, res_rd}, 32'd5);
            end
            if (i == 3) begin
                instr_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        model_write(4'd5, 32'h0000_FF00);
        check_reg(4'd5);
        @(negedge clk);

        // Request change while in EXEC is ignored
        instr_func = 4'd0; instr_rd = 4'd7; instr_rs = 4'd1; instr_rt = 4'd0;
        instr_use_imm = 1'b1; instr_imm = 32'd11; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);   // EXEC
        instr_func = 4'd1; instr_rd = 4'd8; instr_imm = 32'd99;
        @(negedge clk);   // WB
        check("ign_res_rd", {28'd0, res_rd}, 32'd7);
        check("ign_res_data", res_data, 32'd16);
        instr_valid = 1'b0;
        model_write(4'd7, 32'd16);
        @(negedge clk);   // IDLE
        check("ign_ready", {31'd0, instr_ready}, 32'd1);
        check_reg(4'd7);
        check_reg(4'd8);
        @(negedge clk);

        // Write to r0
        do_op(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 32'd9, 1'b1, 32'd9);
`ifdef ALU_SEQ_R0_ZERO_EN
        dbg_addr = 4'd0; #1;
        check("r0_dbg", dbg_data, 32'd0);
`else
        dbg_addr = 4'd0; #1;
        check("r0_dbg", dbg_data, 32'd9);
`endif
        @(negedge clk);

        // Reset during EXEC, held two cycles
        instr_func = 4'd0; instr_rd = 4'd6; instr_rs = 4'd1; instr_rt = 4'd0;
        instr_use_imm = 1'b1; instr_imm = 32'd3; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);   // EXEC
        rst = 1'b1;
        #1;
        check("midrst_res_valid_0", {31'd0, res_valid}, 32'd0);
        check("midrst_alu_a", alu_a, '0);
        @(negedge clk);
        check("midrst_res_valid_1", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        check("midrst_ready", {31'd0, instr_ready}, 32'd1);
        check("midrst_alu_b", alu_b, '0);
        check("midrst_alu_func", {28'd0, alu_func}, 32'd0);
        check("midrst_res_data", res_data, '0);
        check("midrst_res_valid_2", {31'd0, res_valid}, 32'd0);
        check_reg(4'd6);
        check_reg(4'd1);
        @(negedge clk);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            f   = 4'($urandom_range(0, 8));
            rd  = 4'($urandom_range(0, 15));
            rs  = 4'($urandom_range(0, 15));
            rt  = 4'($urandom_range(0, 15));
            ui  = 1'($urandom_range(0, 1));
            imm = $urandom;
            do_op(f, rd, rs, rt, ui, imm, 1'b0, '0);
        end

        // Final register file sweep
        for (int i = 0; i < 16; i++) check_reg(i[3:0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
